// File: rtl/aes_job_ctrl_if.sv
// aes_job_ctrl_if: requester, core-operand and response signals of the AES job
// controller. The slave modport is the controller's view; master is the
// environment (requesters, AES core and response consumer).
interface aes_job_ctrl_if;
    logic         req0_valid;
    logic         req0_ready;
    logic [127:0] req0_data;
    logic [127:0] req0_key;
    logic         req1_valid;
    logic         req1_ready;
    logic [127:0] req1_data;
    logic [127:0] req1_key;
    logic [31:0]  core_data_0;
    logic [31:0]  core_data_1;
    logic [31:0]  core_data_2;
    logic [31:0]  core_data_3;
    logic [31:0]  core_key_0;
    logic [31:0]  core_key_1;
    logic [31:0]  core_key_2;
    logic [31:0]  core_key_3;
    logic [31:0]  core_out_0;
    logic [31:0]  core_out_1;
    logic [31:0]  core_out_2;
    logic [31:0]  core_out_3;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_id;
    logic         busy;

    modport slave (
        input  req0_valid, req0_data, req0_key,
        input  req1_valid, req1_data, req1_key,
        input  core_out_0, core_out_1, core_out_2, core_out_3,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output core_data_0, core_data_1, core_data_2, core_data_3,
        output core_key_0, core_key_1, core_key_2, core_key_3,
        output rsp_valid, rsp_data, rsp_id, busy
    );

    modport master (
        output req0_valid, req0_data, req0_key,
        output req1_valid, req1_data, req1_key,
        output core_out_0, core_out_1, core_out_2, core_out_3,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  core_data_0, core_data_1, core_data_2, core_data_3,
        input  core_key_0, core_key_1, core_key_2, core_key_3,
        input  rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/aes_job_ctrl.sv
// aes_job_ctrl: shares one AES128 core between two requesters. Accepts one
// job at a time, holds the core operands for LATENCY cycles, captures the
// ciphertext and returns it tagged with the requester id.
// Build option: define AES_CTRL_RR_EN for round-robin arbitration; otherwise
// requester 0 has fixed priority.
module aes_job_ctrl #(
    parameter int unsigned LATENCY = 30  // 1..255
) (
    input logic           clk,
    input logic           reset,  // asynchronous, active low
    aes_job_ctrl_if.slave bus
);

    localparam logic [7:0] CntLoad = 8'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [127:0] op_data_q, op_data_d;
    logic [127:0] op_key_q, op_key_d;
    logic [127:0] rsp_data_q, rsp_data_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_id_q, rsp_id_d;
    logic         grant1;
    logic         idle;
    logic         accept0, accept1;

`ifdef AES_CTRL_RR_EN
    logic last_q, last_d;  // 1: requester 1 won the last accept

    // On contention, grant the requester that did not win last time.
    always_comb grant1 = bus.req1_valid && (!bus.req0_valid || !last_q);

    // Record the winner of every accept.
    always_comb begin
        last_d = last_q;
        if (accept0 || accept1) begin
            last_d = accept1;
        end
    end

    // Last-grant register; reset to 1 so the first contention goes to requester 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is idle.
    always_comb grant1 = bus.req1_valid && !bus.req0_valid;
`endif

    // Readies are gated by reset so nothing is offered while reset is held.
    always_comb begin
        idle    = (state_q == StIdle) && reset;
        accept0 = idle && bus.req0_valid && !grant1;
        accept1 = idle && grant1;
    end

    // Next-state and datapath update for the IDLE/WAIT/RESP job sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_data_d   = op_data_q;
        op_key_d    = op_key_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            StIdle: begin
                if (accept0 || accept1) begin
                    op_data_d = accept1 ? bus.req1_data : bus.req0_data;
                    op_key_d  = accept1 ? bus.req1_key : bus.req0_key;
                    rsp_id_d  = accept1;
                    cnt_d     = CntLoad;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    rsp_data_d  = {bus.core_out_3, bus.core_out_2, bus.core_out_1,
                                   bus.core_out_0};
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                // rsp_valid is always high here, so rsp_ready alone completes it.
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, operand and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= 8'd0;
            op_data_q   <= '0;
            op_key_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            op_data_q   <= op_data_d;
            op_key_q    <= op_key_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // Output mapping; word 3 is the most significant.
    always_comb begin
        bus.req0_ready  = accept0;
        bus.req1_ready  = accept1;
        bus.core_data_0 = op_data_q[31:0];
        bus.core_data_1 = op_data_q[63:32];
        bus.core_data_2 = op_data_q[95:64];
        bus.core_data_3 = op_data_q[127:96];
        bus.core_key_0  = op_key_q[31:0];
        bus.core_key_1  = op_key_q[63:32];
        bus.core_key_2  = op_key_q[95:64];
        bus.core_key_3  = op_key_q[127:96];
        bus.rsp_valid   = rsp_valid_q;
        bus.rsp_data    = rsp_data_q;
        bus.rsp_id      = rsp_id_q;
        bus.busy        = (state_q != StIdle);
    end

endmodule

// File: tb/tb_aes_job_ctrl.sv
// tb_aes_job_ctrl: table-driven jobs plus hand-written corner sequences, with
// a scoreboard checking every response against the job that was accepted.
module tb_aes_job_ctrl;

    localparam int LAT = 30;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] GARBAGE  = 128'hbad0bad0_bad0bad0_bad0bad0_bad0bad0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int n_rsp = 0;

    aes_job_ctrl_if bus ();
    aes_job_ctrl_if bus1 ();

    aes_job_ctrl #(.LATENCY(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
    aes_job_ctrl #(.LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // Stub AES: known-answer for the FIPS-197 vector, a simple mix otherwise.
    function automatic logic [127:0] stub_fn(input logic [127:0] d, input logic [127:0] k);
        if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return d ^ {k[95:0], k[127:96]} ^ 128'h5a5a5a5a_0f0f0f0f_a5a5a5a5_f0f0f0f0;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Stub core for the LAT=30 instance: output is garbage until the operands
    // have been stable for LAT cycles.
    logic [127:0] ops_d, ops_k, stub_out;
    logic [255:0] prev_ops = '0;
    int age = 0;
    assign ops_d = {bus.core_data_3, bus.core_data_2, bus.core_data_1, bus.core_data_0};
    assign ops_k = {bus.core_key_3, bus.core_key_2, bus.core_key_1, bus.core_key_0};
    always @(posedge clk) begin
        prev_ops <= {ops_d, ops_k};
        if ({ops_d, ops_k} != prev_ops) age <= 1;
        else if (age < 1000) age <= age + 1;
    end
    assign stub_out = (({ops_d, ops_k} == prev_ops) && (age >= LAT - 1)) ?
                      stub_fn(ops_d, ops_k) : GARBAGE;
    assign bus.core_out_0 = stub_out[31:0];
    assign bus.core_out_1 = stub_out[63:32];
    assign bus.core_out_2 = stub_out[95:64];
    assign bus.core_out_3 = stub_out[127:96];

    // Stub core for the LAT=1 instance: purely combinational.
    logic [127:0] ops1_d, ops1_k, stub1_out;
    assign ops1_d = {bus1.core_data_3, bus1.core_data_2, bus1.core_data_1, bus1.core_data_0};
    assign ops1_k = {bus1.core_key_3, bus1.core_key_2, bus1.core_key_1, bus1.core_key_0};
    assign stub1_out = stub_fn(ops1_d, ops1_k);
    assign bus1.core_out_0 = stub1_out[31:0];
    assign bus1.core_out_1 = stub1_out[63:32];
    assign bus1.core_out_2 = stub1_out[95:64];
    assign bus1.core_out_3 = stub1_out[127:96];

    // Scoreboard: push on accept, check latency on rsp_valid rise, pop on handshake.
    typedef struct {
        logic         id;
        logic [127:0] data;
        int           acc;
    } sb_t;
    sb_t sb[$];
    sb_t e;
    logic prev_rv = 1'b0;

    always @(negedge clk) begin
        #2;
        if (!reset) begin
            sb.delete();
            prev_rv = 1'b0;
        end else begin
            if (bus.req0_valid && bus.req0_ready) begin
                e.id = 1'b0; e.data = stub_fn(bus.req0_data, bus.req0_key); e.acc = cyc + 1;
                sb.push_back(e);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                e.id = 1'b1; e.data = stub_fn(bus.req1_data, bus.req1_key); e.acc = cyc + 1;
                sb.push_back(e);
            end
            if (bus.rsp_valid && !prev_rv) begin
                chk("sb_rsp_expected", sb.size() > 0, 1);
                if (sb.size() > 0) chk("sb_latency", cyc - sb[0].acc, LAT);
            end
            if (bus.rsp_valid && bus.rsp_ready && sb.size() > 0) begin
                e = sb.pop_front();
                n_rsp++;
                chk("sb_data", bus.rsp_data, e.data);
                chk("sb_id", bus.rsp_id, e.id);
            end
            prev_rv = bus.rsp_valid;
        end
    end

    task automatic send(input logic sel, input logic [127:0] d, input logic [127:0] k);
        @(negedge clk);
        if (sel) begin
            bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_key = k;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_key = k;
        end
    endtask

    // Waits for the grant, then drops valid once the accept edge has passed.
    task automatic wait_ready(input logic sel);
        logic ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((sel ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (sel) bus.req1_valid = 1'b0;
        else bus.req0_valid = 1'b0;
        chk("accept_seen", ok, 1);
    endtask

    task automatic wait_rsp();
        logic ok = 1'b0;
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rsp_seen", ok, 1);
    endtask

    task automatic run_job(input logic sel, input logic [127:0] d, input logic [127:0] k,
                           input logic [127:0] exp);
        send(sel, d, k);
        wait_ready(sel);
        wait_rsp();
        chk("job_data", bus.rsp_data, exp);
        chk("job_id", bus.rsp_id, sel);
    endtask

    typedef struct {
        logic         sel;
        logic [127:0] data;
        logic [127:0] key;
        logic [127:0] exp;
    } vec_t;
    vec_t tbl[6];

    logic [127:0] cd0, cd1, bp_a;
    logic r0, r1, hit, seen1, exp_g, seen_rsp;
    int n0;

    initial begin
        tbl[0] = '{sel: 1'b0, data: FIPS_PT, key: FIPS_KEY, exp: FIPS_CT};
        tbl[1] = '{sel: 1'b1, data: '0, key: '0, exp: stub_fn('0, '0)};
        tbl[2] = '{sel: 1'b0, data: '1, key: 128'h0123456789abcdef_fedcba9876543210,
                   exp: stub_fn('1, 128'h0123456789abcdef_fedcba9876543210)};
        tbl[3] = '{sel: 1'b1, data: FIPS_PT, key: 128'h1, exp: stub_fn(FIPS_PT, 128'h1)};
        tbl[4] = '{sel: 1'b0, data: 128'h80000000_0_0_00000001, key: '1,
                   exp: stub_fn(128'h80000000_0_0_00000001, '1)};
        tbl[5] = '{sel: 1'b1, data: FIPS_PT, key: FIPS_KEY, exp: FIPS_CT};

        bus.req0_valid = 1'b1; bus.req0_data = FIPS_PT; bus.req0_key = FIPS_KEY;
        bus.req1_valid = 1'b1; bus.req1_data = '0; bus.req1_key = '0;
        bus.rsp_ready = 1'b1;
        bus1.req0_valid = 1'b1; bus1.req0_data = '0; bus1.req0_key = '0;
        bus1.req1_valid = 1'b0; bus1.req1_data = '0; bus1.req1_key = '0;
        bus1.rsp_ready = 1'b1;

        // Reset state, with requests pending.
        repeat (3) @(negedge clk);
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_req1_ready", bus.req1_ready, 0);
        chk("rst_lat1_req0_ready", bus1.req0_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_core_data", ops_d, 0);
        chk("rst_core_key", ops_k, 0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus1.req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Single jobs from the table, rsp_ready held high.
        for (int i = 0; i < 6; i++) begin
            run_job(tbl[i].sel, tbl[i].data, tbl[i].key, tbl[i].exp);
        end

        // Minimum latency instance: response one cycle after accept.
        @(negedge clk);
        bus1.req0_valid = 1'b1; bus1.req0_data = 128'hcafe; bus1.req0_key = 128'hbeef;
        #1 chk("lat1_ready", bus1.req0_ready, 1);
        @(negedge clk);
        bus1.req0_valid = 1'b0;
        #1 chk("lat1_wait_no_rsp", bus1.rsp_valid, 0);
        chk("lat1_busy", bus1.busy, 1);
        @(negedge clk);
        #1 chk("lat1_rsp_valid", bus1.rsp_valid, 1);
        chk("lat1_rsp_data", bus1.rsp_data, stub_fn(128'hcafe, 128'hbeef));
        chk("lat1_rsp_id", bus1.rsp_id, 0);

        // Backpressure: hold the response for 50 cycles with requester 1 waiting.
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bp_a = 128'h0a0a0a0a_11111111_22222222_33333333;
        send(1'b0, bp_a, FIPS_KEY);
        wait_ready(1'b0);
        wait_rsp();
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_data = 128'hb0b0; bus.req1_key = 128'h77;
        for (int i = 0; i < 50; i++) begin
            #1;
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_data", bus.rsp_data, stub_fn(bp_a, FIPS_KEY));
            chk("bp_rsp_id", bus.rsp_id, 0);
            chk("bp_req1_ready", bus.req1_ready, 0);
            chk("bp_core_data", ops_d, bp_a);
            chk("bp_core_key", ops_k, FIPS_KEY);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1 chk("bp_next_accept", bus.req1_ready, 1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        wait_rsp();
        chk("bp_next_data", bus.rsp_data, stub_fn(128'hb0b0, 128'h77));

        // Reset ten cycles into WAIT: outputs clear at once, no response follows.
        send(1'b1, 128'h1234, 128'h5678);
        wait_ready(1'b1);
        repeat (10) @(negedge clk);
        bus.req0_valid = 1'b1;
        reset = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_rsp_data", bus.rsp_data, 0);
        chk("mid_rst_rsp_id", bus.rsp_id, 0);
        chk("mid_rst_core_data", ops_d, 0);
        chk("mid_rst_core_key", ops_k, 0);
        chk("mid_rst_req0_ready", bus.req0_ready, 0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen_rsp = 1'b0;
        repeat (LAT + 10) begin
            @(negedge clk);
            #1 seen_rsp = seen_rsp | bus.rsp_valid | bus.busy;
        end
        chk("mid_rst_no_rsp", seen_rsp, 0);
        run_job(1'b0, FIPS_PT, FIPS_KEY, FIPS_CT);

        // Contention from a fresh reset: both requesters valid continuously.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n0 = n_rsp;
        seen1 = 1'b0;
        cd0 = 128'h1000; cd1 = 128'h2000;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_data = cd0; bus.req0_key = 128'haaaa;
        bus.req1_valid = 1'b1; bus.req1_data = cd1; bus.req1_key = 128'hbbbb;
        for (int g = 0; g < 4; g++) begin
            hit = 1'b0; r0 = 1'b0; r1 = 1'b0;
            for (int i = 0; i < LAT + 20; i++) begin
                #1;
                r0 = bus.req0_ready; r1 = bus.req1_ready;
                seen1 = seen1 | r1;
                if (r0 || r1) begin
                    hit = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("cont_grant_seen", hit, 1);
            chk("cont_onehot", {1'b0, r0} + {1'b0, r1}, 1);
`ifdef AES_CTRL_RR_EN
            exp_g = (g % 2) == 1;
`else
            exp_g = 1'b0;
`endif
            chk("cont_grant_id", r1, exp_g);
            @(negedge clk);
            if (r1) begin
                cd1 = cd1 + 1; bus.req1_data = cd1;
            end else begin
                cd0 = cd0 + 1; bus.req0_data = cd0;
            end
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !bus.busy) break;
        end
        chk("cont_drained", sb.size(), 0);
        chk("cont_rsp_count", n_rsp - n0, 4);
`ifndef AES_CTRL_RR_EN
        chk("cont_req1_never_ready", seen1, 0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: test did not complete (%0d failures so far)", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
